// File: rtl/minefield_board_pkg.sv
// Shared definitions for the minefield board.
//   state_t   : controller states (IDLE, INC, CLR)
//   NB_DX/DY  : the eight neighbour offsets in the order INC visits them
//   sat_inc   : increment that saturates at 2^w-1 (w < 64)
package board_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INC  = 2'd1,
    CLR  = 2'd2
  } state_t;

  // Row-major walk around the centre cell, skipping the centre itself.
  localparam logic signed [1:0] NB_DX [8] = '{
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1,        2'sd1,
    -2'sd1, 2'sd0, 2'sd1
  };
  localparam logic signed [1:0] NB_DY [8] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,          2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/minefield_board_if.sv
// Bundle between the game controller (master) and the board (slave).
//   read port : readX/readY -> readValue (combinational)
//   write port: writeEn, writeX/writeY, writeValue
//   commands  : incAdjacent (around writeX/writeY), clearBoard
//   status    : busy, done, state (debug view of the board controller)
//
// Handshake: a request (writeEn, incAdjacent, clearBoard) is sampled only on
// a rising edge where busy=0; while busy=1 every request is dropped, not
// queued. done pulses for exactly one cycle, the last busy cycle of a
// sequenced command; busy falls on the following edge and the next request
// can be accepted from that cycle on.
interface minefield_board_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int CELL_W = 8
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic [XW-1:0]     readX;
  logic [YW-1:0]     readY;
  logic [CELL_W-1:0] readValue;
  logic              writeEn;
  logic [XW-1:0]     writeX;
  logic [YW-1:0]     writeY;
  logic [CELL_W-1:0] writeValue;
  logic              incAdjacent;
  logic              clearBoard;
  logic              busy;
  logic              done;
  board_pkg::state_t state;

  modport master (
    output readX, readY, writeEn, writeX, writeY, writeValue,
           incAdjacent, clearBoard,
    input  readValue, busy, done, state
  );

  modport slave (
    input  readX, readY, writeEn, writeX, writeY, writeValue,
           incAdjacent, clearBoard,
    output readValue, busy, done, state
  );

endinterface

// File: rtl/minefield_board_neighbour_gen.sv
// Combinational neighbour coordinate generator.
//   cx, cy   : centre cell (assumed in range)
//   k        : neighbour number 0..7, offsets from board_pkg
//   nx, ny   : neighbour coordinates (valid only when inBounds)
//   inBounds : neighbour lies on the board
module board_neighbour_gen
  import board_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic [XW-1:0] cx,
  input  logic [YW-1:0] cy,
  input  logic [2:0]    k,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny,
  output logic          inBounds
);

  logic signed [XW:0] sx;
  logic signed [YW:0] sy;

  // One extra bit holds -1. The centre is at most 2^XW-1, so centre+1 can
  // reach 2^XW, which wraps to a negative value here; that only happens
  // when the neighbour is past the last column, so the sign bit still marks
  // it as off-board.
  assign sx = $signed({1'b0, cx}) + (XW+1)'(NB_DX[k]);
  assign sy = $signed({1'b0, cy}) + (YW+1)'(NB_DY[k]);

  assign inBounds = !sx[XW] && !sy[YW] &&
                    (int'(sx) < WIDTH) && (int'(sy) < HEIGHT);
  assign nx = sx[XW-1:0];
  assign ny = sy[YW-1:0];

endmodule

// File: rtl/minefield_board.sv
// Minesweeper board cell store with sequenced commands.
//   clk, reset : clock and asynchronous active-high reset (clears all cells)
//   bus        : slave side of minefield_board_if
//                - asynchronous read of cell (readX, readY), 0 if off-board
//                - direct write of writeValue to (writeX, writeY) when idle
//                - incAdjacent: saturating +1 on the 8 neighbours of
//                  (writeX, writeY), one neighbour per cycle (8 cycles)
//                - clearBoard: zero one cell per cycle (WIDTH*HEIGHT cycles)
//                - busy/done status, state as a debug view
module minefield_board
  import board_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int CELL_W = 8,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic        clk,
  input  logic        reset,
  minefield_board_if.slave bus
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);

  logic [CELL_W-1:0] cells [N];

  state_t        state;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [2:0]    k;
  logic [IW-1:0] s;
  logic          busy_q;
  logic          done_q;

  // Read port: coordinates are checked before the linear index is used, so
  // the truncating cast below never aliases an off-board cell.
  logic          r_in;
  logic [IW-1:0] r_idx;

  assign r_in  = (int'(bus.readX) < WIDTH) && (int'(bus.readY) < HEIGHT);
  assign r_idx = IW'(int'(bus.readY) * WIDTH + int'(bus.readX));
  assign bus.readValue = r_in ? cells[r_idx] : '0;

  // Write / command coordinates.
  logic          w_in;
  logic [IW-1:0] w_idx;

  assign w_in  = (int'(bus.writeX) < WIDTH) && (int'(bus.writeY) < HEIGHT);
  assign w_idx = IW'(int'(bus.writeY) * WIDTH + int'(bus.writeX));

  // Current neighbour during INC.
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          n_in;
  logic [IW-1:0] n_idx;

  board_neighbour_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_nb (
    .cx       (cx),
    .cy       (cy),
    .k        (k),
    .nx       (nx),
    .ny       (ny),
    .inBounds (n_in)
  );

  assign n_idx = IW'(int'(ny) * WIDTH + int'(nx));

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state;

  // done is registered one step early so it is high during the last busy
  // cycle (k=7 / s=N-1) rather than after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cells[i] <= '0;
      state  <= IDLE;
      cx     <= '0;
      cy     <= '0;
      k      <= '0;
      s      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.clearBoard) begin
            s      <= '0;
            state  <= CLR;
            busy_q <= 1'b1;
          end else if (bus.writeEn) begin
            // An off-board write still outranks incAdjacent: it is dropped
            // and so is the lower-priority request.
            if (w_in) cells[w_idx] <= bus.writeValue;
          end else if (bus.incAdjacent && w_in) begin
            cx     <= bus.writeX;
            cy     <= bus.writeY;
            k      <= '0;
            state  <= INC;
            busy_q <= 1'b1;
          end
        end

        INC: begin
          if (n_in) cells[n_idx] <= CELL_W'(sat_inc(64'(cells[n_idx]), CELL_W));
          k      <= k + 3'd1;
          done_q <= (k == 3'd6);
          if (k == 3'd7) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        CLR: begin
          cells[s] <= '0;
          s        <= s + IW'(1);
          done_q   <= (s == IW'(N - 2));
          if (s == IW'(N - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minefield_board.sv
module tb_minefield_board;
  import board_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CW = 8;
  localparam int MAXV = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  minefield_board_if #(.WIDTH(W), .HEIGHT(H), .CELL_W(CW)) bus ();

  minefield_board #(.WIDTH(W), .HEIGHT(H), .CELL_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  int model [H][W];
  int errors = 0;
  int checks = 0;

  function automatic void model_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) model[y][x] = 0;
  endfunction

  // Every in-range cell in the 3x3 square around the centre, except the
  // centre, goes up by one, stopping at MAXV.
  function automatic void model_inc(input int cx, input int cy);
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int x, y;
        x = cx + dx;
        y = cy + dy;
        if (!(dx == 0 && dy == 0) && x >= 0 && x < W && y >= 0 && y < H)
          if (model[y][x] < MAXV) model[y][x] = model[y][x] + 1;
      end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_board(input string tag);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        bus.readX = 3'(x);
        bus.readY = 3'(y);
        #1;
        check($sformatf("%s(%0d,%0d)", tag, x, y), 32'(bus.readValue), 32'(model[y][x]));
      end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.readX       = '0;
    bus.readY       = '0;
    bus.writeEn     = 1'b0;
    bus.writeX      = '0;
    bus.writeY      = '0;
    bus.writeValue  = '0;
    bus.incAdjacent = 1'b0;
    bus.clearBoard  = 1'b0;
  endtask

  task automatic do_write(input int x, input int y, input int v);
    bus.writeX     = 3'(x);
    bus.writeY     = 3'(y);
    bus.writeValue = 8'(v);
    bus.writeEn    = 1'b1;
    tick();
    bus.writeEn    = 1'b0;
    model[y][x]    = v;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    tick();
    model_clear();
  endtask

  task automatic fill_board(input int v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) do_write(x, y, v);
  endtask

  // kind: 1 = incAdjacent, 2 = clearBoard, 3 = all three requests at once.
  // inj_kind: 0 none, 1 writeEn, 2 incAdjacent; inj_at: busy-cycle number
  // at which to inject, or -1 to inject during the done cycle.
  task automatic run_cmd(input int kind, input int x, input int y,
                         input int inj_kind, input int inj_at,
                         input int ix, input int iy, input int iv,
                         output int busy_cnt, output int done_at,
                         output int done_cnt, output int first_state);
    int finished;
    bit inject;
    bus.writeX      = 3'(x);
    bus.writeY      = 3'(y);
    bus.writeValue  = 8'($urandom_range(1, 255));
    bus.incAdjacent = (kind == 1 || kind == 3);
    bus.clearBoard  = (kind == 2 || kind == 3);
    bus.writeEn     = (kind == 3);
    tick();
    idle_inputs();
    first_state = int'(bus.state);
    busy_cnt = 0;
    done_at  = 0;
    done_cnt = 0;
    finished = 0;
    for (int i = 0; i < 200 && finished == 0; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      if (bus.busy !== 1'b1) begin
        finished = 1;
      end else begin
        inject = (inj_kind != 0) &&
                 ((inj_at > 0 && busy_cnt == inj_at) || (inj_at < 0 && bus.done === 1'b1));
        bus.writeX      = 3'(ix);
        bus.writeY      = 3'(iy);
        bus.writeValue  = 8'(iv);
        bus.writeEn     = inject && inj_kind == 1;
        bus.incAdjacent = inject && inj_kind == 2;
        tick();
        bus.writeEn     = 1'b0;
        bus.incAdjacent = 1'b0;
      end
    end
    check("cmd_finished", 32'(finished), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc, da, dc, fs, cnt, x, y, v;

    idle_inputs();
    model_clear();

    // Power-on reset.
    reset = 1'b1;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    @(negedge clk) reset = 1'b0;
    tick();

    // Random traffic, then an asynchronous reset mid-stream.
    for (int i = 0; i < 12; i++)
      do_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 255));
    #3 reset = 1'b1;
    #1;
    model_clear();
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check_board("midrst");
    @(negedge clk) reset = 1'b0;
    tick();

    // Centre increment.
    run_cmd(1, 3, 3, 0, 0, 0, 0, 0, bc, da, dc, fs);
    model_inc(3, 3);
    check("c33_state", 32'(fs), 32'(INC));
    check("c33_busy_cycles", 32'(bc), 32'd8);
    check("c33_done_at", 32'(da), 32'd8);
    check("c33_done_cnt", 32'(dc), 32'd1);
    check_board("c33");

    // Corner clipping.
    do_reset();
    run_cmd(1, 0, 0, 0, 0, 0, 0, 0, bc, da, dc, fs);
    model_inc(0, 0);
    check("c00_busy_cycles", 32'(bc), 32'd8);
    check("c00_done_at", 32'(da), 32'd8);
    check_board("c00");

    // Edge clipping at (7,4): five neighbours on the board.
    do_reset();
    run_cmd(1, 7, 4, 0, 0, 0, 0, 0, bc, da, dc, fs);
    model_inc(7, 4);
    check("c74_busy_cycles", 32'(bc), 32'd8);
    check_board("c74");
    cnt = 0;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        bus.readX = 3'(xx);
        bus.readY = 3'(yy);
        #1;
        if (bus.readValue == 8'd1) cnt++;
      end
    check("c74_ones", 32'(cnt), 32'd5);

    // Saturation, plus a write issued mid-INC that must be dropped.
    do_reset();
    do_write(1, 1, 255);
    run_cmd(1, 0, 0, 1, 3, 5, 5, 9, bc, da, dc, fs);
    model_inc(0, 0);
    check("sat_busy_cycles", 32'(bc), 32'd8);
    check_board("sat");

    // Random writes and increments, including near-saturated values.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        x = $urandom_range(0, 7);
        y = $urandom_range(0, 7);
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(253, 255) : $urandom_range(0, 255);
        do_write(x, y, v);
      end
      x = $urandom_range(0, 7);
      y = $urandom_range(0, 7);
      run_cmd(1, x, y, 0, 0, 0, 0, 0, bc, da, dc, fs);
      model_inc(x, y);
      check($sformatf("rnd%0d_busy_cycles", r), 32'(bc), 32'd8);
      check($sformatf("rnd%0d_done_cnt", r), 32'(dc), 32'd1);
      check_board($sformatf("rnd%0d", r));
    end

    // Request raised during the done cycle is dropped.
    run_cmd(1, 2, 6, 2, -1, 5, 1, 0, bc, da, dc, fs);
    model_inc(2, 6);
    check("b2b_busy_cycles", 32'(bc), 32'd8);
    tick();
    check("b2b_idle_busy", 32'(bus.busy), 32'd0);
    check_board("b2b");

    // Full clear sweep.
    fill_board(7);
    run_cmd(2, 0, 0, 0, 0, 0, 0, 0, bc, da, dc, fs);
    model_clear();
    check("clr_state", 32'(fs), 32'(CLR));
    check("clr_busy_cycles", 32'(bc), 32'd64);
    check("clr_done_at", 32'(da), 32'd64);
    check("clr_done_cnt", 32'(dc), 32'd1);
    check_board("clr");

    // Clear sweep aborted by reset at sweep cycle 20.
    fill_board(7);
    bus.clearBoard = 1'b1;
    tick();
    bus.clearBoard = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 20; i++) begin
      if (bus.busy === 1'b1) cnt++;
      if (cnt < 20) tick();
    end
    check("abort_reached", 32'(cnt), 32'd20);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_state", 32'(bus.state), 32'(IDLE));
    @(negedge clk) reset = 1'b0;
    tick();
    bc = 0;
    dc = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.busy !== 1'b0) bc++;
      if (bus.done !== 1'b0) dc++;
      tick();
    end
    check("abort_no_busy", 32'(bc), 32'd0);
    check("abort_no_done", 32'(dc), 32'd0);
    check_board("abort");

    // Priority: all three requests together -> clear only.
    for (int i = 0; i < 8; i++)
      do_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 200));
    run_cmd(3, 4, 4, 0, 0, 0, 0, 0, bc, da, dc, fs);
    model_clear();
    check("prio_state", 32'(fs), 32'(CLR));
    check("prio_busy_cycles", 32'(bc), 32'd64);
    check("prio_done_cnt", 32'(dc), 32'd1);
    check_board("prio");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
